// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module   : sram_controller
// Purpose  : Memory-stage responder that stores each 32-bit word as two
//            consecutive 16-bit SRAM locations (low half at the even
//            address, high half at the odd address), freezing the pipeline
//            through a fixed-latency access sequence.
// Revision : 1.0 - initial release
// ============================================================================
module sram_controller #(
   parameter int unsigned WAIT_CYCLES = 2,          // idle bus cycles after HIGH, 0..15
   parameter logic [31:0] BASE_ADDR   = 32'd1024    // byte address of word 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic [17:0] sram_addr,
   output logic [15:0] sram_dq_out,
   output logic        sram_dq_oe,
   input  logic [15:0] sram_dq_in,
   output logic        sram_we_n
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOW  = 3'd1,
      HIGH = 3'd2,
      WAIT = 3'd3,
      DONE = 3'd4
   } state_t;

   // Loaded into the wait counter on leaving HIGH; only meaningful when
   // WAIT_CYCLES > 0, so the wrap at WAIT_CYCLES == 0 is never used.
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES) - 4'd1;

   state_t      state;
   logic        op_write;
   logic [16:0] index_lat;
   logic [31:0] data_lat;
   logic [3:0]  wait_cnt;
   logic [16:0] index_in;

   // Word index relative to the data-memory base; wraps modulo 2^32 and
   // drops the byte offset bits.
   assign index_in = 17'((address - BASE_ADDR) >> 2);

   // Freeze the pipeline while a request is pending and not yet completed.
   assign ready = ~(rd_en | wr_en) | (state == DONE);

   // Access sequencer with registered SRAM bus outputs and read capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         op_write    <= 1'b0;
         index_lat   <= '0;
         data_lat    <= '0;
         wait_cnt    <= '0;
         read_data   <= '0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
      end else begin
         // Bus is quiet unless the next state is LOW or HIGH.
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;

         case (state)
            IDLE: begin
               if (rd_en | wr_en) begin
                  op_write  <= wr_en;
                  index_lat <= index_in;
                  data_lat  <= write_data;
                  state     <= LOW;
                  sram_addr <= {index_in, 1'b0};
                  if (wr_en) begin
                     sram_we_n   <= 1'b0;
                     sram_dq_oe  <= 1'b1;
                     sram_dq_out <= write_data[15:0];
                  end
               end
            end

            LOW: begin
               if (!op_write) begin
                  read_data[15:0] <= sram_dq_in;
               end
               state     <= HIGH;
               sram_addr <= {index_lat, 1'b1};
               if (op_write) begin
                  sram_we_n   <= 1'b0;
                  sram_dq_oe  <= 1'b1;
                  sram_dq_out <= data_lat[31:16];
               end
            end

            HIGH: begin
               if (!op_write) begin
                  read_data[31:16] <= sram_dq_in;
               end
               if (WAIT_CYCLES > 0) begin
                  state    <= WAIT;
                  wait_cnt <= WAIT_INIT;
               end else begin
                  state <= DONE;
               end
            end

            WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state <= DONE;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_controller
// Purpose  : Directed bench for sram_controller: a default-latency instance
//            and a WAIT_CYCLES=0 instance, each with its own SRAM model.
//            Expected read_data values are queued when a request is issued
//            and popped when the controller reports completion.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_controller;

   localparam logic [31:0] BASE = 32'd1024;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Instance 0: default parameters
   logic        wr0, rd0, ready0, oe0, we0;
   logic [31:0] a0, d0, rdata0;
   logic [17:0] saddr0;
   logic [15:0] sout0, sin0;
   // Instance 1: WAIT_CYCLES = 0
   logic        wr1, rd1, ready1, oe1, we1;
   logic [31:0] a1, d1, rdata1;
   logic [17:0] saddr1;
   logic [15:0] sout1, sin1;

   sram_controller dut0 (
      .clk(clk), .rst(rst), .wr_en(wr0), .rd_en(rd0), .address(a0),
      .write_data(d0), .read_data(rdata0), .ready(ready0), .sram_addr(saddr0),
      .sram_dq_out(sout0), .sram_dq_oe(oe0), .sram_dq_in(sin0), .sram_we_n(we0)
   );

   sram_controller #(.WAIT_CYCLES(0)) dut1 (
      .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1), .address(a1),
      .write_data(d1), .read_data(rdata1), .ready(ready1), .sram_addr(saddr1),
      .sram_dq_out(sout1), .sram_dq_oe(oe1), .sram_dq_in(sin1), .sram_we_n(we1)
   );

   // Asynchronous-read, clocked-write SRAM models
   logic [15:0] mem0 [262144];
   logic [15:0] mem1 [262144];
   always @(posedge clk) if (!we0) mem0[saddr0] <= sout0;
   always @(posedge clk) if (!we1) mem1[saddr1] <= sout1;
   assign sin0 = mem0[saddr0];
   assign sin1 = mem1[saddr1];

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q [$];
   logic [31:0] word_model [logic [17:0]];
   logic [31:0] last_rd [2];

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   function automatic logic [31:0] obs(input bit s, input int k);
      case (k)
         0:       return s ? 32'(ready1) : 32'(ready0);
         1:       return s ? 32'(saddr1) : 32'(saddr0);
         2:       return s ? 32'(we1)    : 32'(we0);
         3:       return s ? 32'(oe1)    : 32'(oe0);
         4:       return s ? 32'(sout1)  : 32'(sout0);
         default: return s ? rdata1      : rdata0;
      endcase
   endfunction

   task automatic set_req(input bit s, input logic w, input logic r,
                          input logic [31:0] a, input logic [31:0] d);
      if (s) begin
         wr1 = w; rd1 = r; a1 = a; d1 = d;
      end else begin
         wr0 = w; rd0 = r; a0 = a; d0 = d;
      end
   endtask

   // Issue one access from IDLE (called #1 after a clock edge) and check it
   // cycle by cycle; returns #1 after the DONE->IDLE edge.
   task automatic access(input bit s, input logic w, input logic r,
                         input logic [31:0] a, input logic [31:0] d,
                         input bit scramble, input bit rel);
      int          wc;
      logic [16:0] idx;
      logic [31:0] e;
      logic [15:0] half;
      logic        hi;
      wc  = s ? 0 : 2;
      idx = 17'((a - BASE) >> 2);
      if (w) begin
         word_model[{s, idx}] = d;
         e = last_rd[s];
      end else begin
         e = word_model.exists({s, idx}) ? word_model[{s, idx}] : 32'h0;
         last_rd[s] = e;
      end
      exp_q.push_back(e);
      set_req(s, w, r, a, d);
      for (int c = 0; c <= 3 + wc; c++) begin
         @(negedge clk);
         chk("ready", obs(s, 0), 32'(c == 3 + wc));
         if (c == 1 || c == 2) begin
            hi   = (c == 2);
            half = hi ? d[31:16] : d[15:0];
            chk("sram_addr", obs(s, 1), 32'({idx, hi}));
            chk("sram_we_n", obs(s, 2), 32'(!w));
            chk("sram_dq_oe", obs(s, 3), 32'(w));
            chk("sram_dq_out", obs(s, 4), w ? 32'(half) : 32'h0);
         end else if (c >= 3) begin
            chk("idle_addr", obs(s, 1), 32'h0);
            chk("idle_we_n", obs(s, 2), 32'h1);
         end
         if (c == 3 + wc) begin
            if (exp_q.size() == 0) begin
               chk("scoreboard_empty", 32'h1, 32'h0);
            end else begin
               chk("read_data", obs(s, 5), exp_q.pop_front());
            end
         end
         if (scramble && c == 1) set_req(s, w, r, ~a, ~d);
         @(posedge clk);
         #1;
      end
      if (rel) set_req(s, 1'b0, 1'b0, a, d);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;
      rst = 1'b1;
      set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state and ten request-free cycles
      @(negedge clk);
      chk("rst_read_data", rdata0, 32'h0);
      chk("rst_addr", 32'(saddr0), 32'h0);
      chk("rst_dq_out", 32'(sout0), 32'h0);
      chk("rst_read_data1", rdata1, 32'h0);
      for (int i = 0; i < 10; i++) begin
         chk("noreq_ready", 32'(ready0), 32'h1);
         chk("noreq_we_n", 32'(we0), 32'h1);
         chk("noreq_oe", 32'(oe0), 32'h0);
         @(posedge clk); #1;
         @(negedge clk);
      end
      @(posedge clk); #1;

      // Write 0xDEADBEEF at the base address
      access(0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0, 1'b1);
      @(negedge clk);
      chk("mem0_0", 32'(mem0[0]), 32'h0000BEEF);
      chk("mem0_1", 32'(mem0[1]), 32'h0000DEAD);
      @(posedge clk); #1;

      // Read it back, disturbing address after acceptance
      access(0, 1'b0, 1'b1, 32'd1024, 32'h0, 1'b1, 1'b1);
      @(negedge clk);
      chk("read_hold", rdata0, 32'hDEADBEEF);
      @(posedge clk); #1;

      // Write priority and negative-offset wrap
      access(0, 1'b1, 1'b1, 32'd1020, 32'h12345678, 1'b1, 1'b1);
      @(negedge clk);
      chk("wrap_lo", 32'(mem0[18'h3FFFE]), 32'h00005678);
      chk("wrap_hi", 32'(mem0[18'h3FFFF]), 32'h00001234);
      chk("wrap_rd_keep", rdata0, 32'hDEADBEEF);
      @(posedge clk); #1;

      // Reset during HIGH of a write aborts it
      set_req(0, 1'b1, 1'b0, 32'd2048, 32'hA5A55A5A);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_in_high", 32'(saddr0), 32'(18'd513));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
      last_rd[0] = 32'h0;
      @(negedge clk);
      chk("abort_we_n", 32'(we0), 32'h1);
      chk("abort_oe", 32'(oe0), 32'h0);
      chk("abort_addr", 32'(saddr0), 32'h0);
      chk("abort_read_data", rdata0, 32'h0);
      chk("abort_ready", 32'(ready0), 32'h1);
      @(posedge clk); #1;
      access(0, 1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, 1'b1);

      // Zero-wait instance: two writes, then back-to-back reads
      access(1, 1'b1, 1'b0, 32'd1064, 32'hCAFEF00D, 1'b0, 1'b1);
      access(1, 1'b1, 1'b0, 32'd1424, 32'h01234567, 1'b0, 1'b1);
      access(1, 1'b0, 1'b1, 32'd1064, 32'h0, 1'b0, 1'b0);
      access(1, 1'b0, 1'b1, 32'd1424, 32'h0, 1'b0, 1'b1);
      @(negedge clk);
      chk("b2b_ready_after", 32'(ready1), 32'h1);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
